serial_add_ctrl: RTL and testbench

Bit-serial adder controller. It sequences a single one-bit full-adder slice over WIDTH clock cycles to produce a WIDTH-bit sum and carry-out. It owns the operand shift registers, the carry flip-flop, the bit counter and a start/done handshake. It is the area-minimal alternative to a ripple-carry chain, for use wherever add latency is not critical.

---
 rtl/serial_add_pkg.sv | 26 ++
 rtl/serial_add_slice.sv | 42 ++++
 rtl/serial_add_ctrl.sv | 170 +++++++++++++++++
 tb/tb_serial_add_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_pkg
//  Description : Shared types and constants for the bit-serial adder
//                controller: FSM state encoding and legal WIDTH bounds.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    // FSM state encoding; 2'b11 is unused and recovers to ST_IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam int c_WIDTH_MIN = 1;
    localparam int c_WIDTH_MAX = 32;

    // True when an operand width is inside the supported range
    function automatic bit width_ok(input int w);
        return (w >= c_WIDTH_MIN) && (w <= c_WIDTH_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_slice.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_slice
//  Description : One-bit full-adder slice plus the carry flip-flop that
//                threads the carry between successive serial bit positions.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_slice (
    input  logic clk,
    input  logic rst_n,
    input  logic load,      // preload carry with load_val (start of an add)
    input  logic load_val,
    input  logic en,        // advance carry by one bit position
    input  logic a_bit,
    input  logic b_bit,
    output logic s,
    output logic c,
    output logic carry      // current carry flop value (carry into this bit)
);

    logic w_p;
    logic r_carry;

    // Full-adder cell: propagate, sum and carry-out for the current bit
    assign w_p   = a_bit ^ b_bit;
    assign s     = w_p ^ r_carry;
    assign c     = (a_bit & b_bit) | (r_carry & w_p);
    assign carry = r_carry;

    // Carry flop: preload on start, otherwise follow carry-out while shifting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
        end else if (load) begin
            r_carry <= load_val;
        end else if (en) begin
            r_carry <= c;
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_ctrl
//  Description : Bit-serial adder controller. Sequences a one-bit slice over
//                WIDTH cycles (LSB first) with a start/done handshake.
//                Optional macro SERIAL_ADD_SUB_EN adds a 'sub' input
//                (a-b via ~b and carry-in 1) and a signed-overflow output.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (!width_ok(WIDTH)) begin : g_width_check
            $error("serial_add_ctrl: WIDTH out of range");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_shift;
    logic             w_illegal;
    logic             w_last;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_cin_load;
    logic             w_s;
    logic             w_c;
    logic             w_carry;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1; the external carry-in is ignored
    assign w_b_load   = sub ? ~b : b;
    assign w_cin_load = sub ? 1'b1 : cin;
`else
    assign w_b_load   = b;
    assign w_cin_load = cin;
`endif

    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    // New sum bit enters at the MSB while the partial result moves right
    assign w_res_next = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

    serial_add_slice u_slice (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_cin_load),
        .en       (w_shift),
        .a_bit    (r_sa[0]),
        .b_bit    (r_sb[0]),
        .s        (w_s),
        .c        (w_c),
        .carry    (w_carry)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, datapath strobes and handshake outputs
    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_shift   = 1'b0;
        w_illegal = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy    = 1'b1;
                w_shift = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_illegal = 1'b1;
                w_next    = ST_IDLE;
            end
        endcase
    end

    // Operand shifters, bit counter and result; ports update only on the last bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sa  <= '0;
            r_sb  <= '0;
            r_cnt <= '0;
            r_res <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            ovf   <= 1'b0;
`endif
        end else if (w_load) begin
            r_sa  <= a;
            r_sb  <= w_b_load;
            r_cnt <= '0;
        end else if (w_shift) begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
            r_res <= w_res_next;
            if (w_last) begin
                sum  <= w_res_next;
                cout <= w_c;
`ifdef SERIAL_ADD_SUB_EN
                // Carry into the MSB is the flop value on the final bit
                ovf  <= w_carry ^ w_c;
`endif
            end
        end else if (w_illegal) begin
            sum  <= '0;
            cout <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            ovf  <= 1'b0;
`endif
        end
    end

`ifndef SERIAL_ADD_SUB_EN
    // Carry-into-MSB only matters for the overflow output
    logic w_unused;
    assign w_unused = w_carry;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_ctrl
//  Description : Self-checking bench for serial_add_ctrl (WIDTH=8 and
//                WIDTH=1 instances) against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n, start, cin;
    logic [W-1:0] a, b, sum;
    logic         busy, done, cout;
    logic         start1, cin1, busy1, done1, cout1;
    logic [0:0]   a1, b1, sum1;
`ifdef SERIAL_ADD_SUB_EN
    logic sub, ovf, sub1, ovf1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub), .ovf(ovf),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub1), .ovf(ovf1),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    // Reference: {cout,sum} from plain integer arithmetic
    function automatic logic [W:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic ci, input logic op_sub);
        int t;
        logic [W:0] r;
        if (op_sub) begin
            t = int'(x) - int'(y);
            r[W-1:0] = t[W-1:0];
            r[W] = (x >= y);
        end else begin
            t = int'(x) + int'(y) + int'(ci);
            r = t[W:0];
        end
        return r;
    endfunction

    // Reference: signed overflow of the same operation on signed operands
    function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic op_sub);
        int sx, sy, r;
        sx = (x >= 128) ? int'(x) - 256 : int'(x);
        sy = (y >= 128) ? int'(y) - 256 : int'(y);
        r  = op_sub ? sx - sy : sx + sy + int'(ci);
        return (r > 127) || (r < -128);
    endfunction

    // Launch one operation, scramble inputs after acceptance, wait for done
    task automatic run_op8(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                           input logic op_sub, output logic [W-1:0] s, output logic co,
                           output logic ov, output int lat, output logic seq_ok);
        logic [W-1:0] prev;
        logic         prev_co;
        @(negedge clk);
        prev = sum; prev_co = cout;
        a = x; b = y; cin = ci; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub = op_sub;
`endif
        lat = 0; seq_ok = 1'b1;
        while (lat < 40) begin
            @(negedge clk);
            start = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            sub = 1'($urandom);
`endif
            lat++;
            if (busy !== 1'b1) seq_ok = 1'b0;
            if (done === 1'b1) break;
            if (sum !== prev || cout !== prev_co) seq_ok = 1'b0;
        end
        s = sum; co = cout;
`ifdef SERIAL_ADD_SUB_EN
        ov = ovf;
`else
        ov = 1'b0;
        if (op_sub) ov = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start1 = 1'b0;
        a = '0; b = '0; cin = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0; sub1 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cout, sum} !== '0) begin
            errors++;
            $display("FAIL reset_w8 got busy=%0b done=%0b cout=%0b sum=%0d exp all 0", busy, done, cout, sum);
        end
        checks++;
        if ({busy1, done1, cout1, sum1} !== '0) begin
            errors++;
            $display("FAIL reset_w1 got busy=%0b done=%0b cout=%0b sum=%0d exp all 0", busy1, done1, cout1, sum1);
        end
`ifdef SERIAL_ADD_SUB_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %0b exp 0", ovf);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] s; logic co, ov, ok; int lat;
        run_op8(8'd13, 8'd29, 1'b0, 1'b0, s, co, ov, lat, ok);
        checks++;
        if (lat !== W + 1) begin errors++; $display("FAIL basic_latency got %0d exp %0d", lat, W + 1); end
        checks++;
        if (s !== 8'd42 || co !== 1'b0) begin errors++; $display("FAIL basic_sum got %0d/%0b exp 42/0", s, co); end
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL basic_busy_hold got %0b exp 1", ok); end
    endtask

    task automatic test_carry();
        logic [W-1:0] s; logic co, ov, ok; int lat;
        run_op8(8'd255, 8'd1, 1'b0, 1'b0, s, co, ov, lat, ok);
        checks++;
        if (s !== 8'd0 || co !== 1'b1) begin errors++; $display("FAIL carry_wrap got %0d/%0b exp 0/1", s, co); end
        run_op8(8'd200, 8'd100, 1'b1, 1'b0, s, co, ov, lat, ok);
        checks++;
        if (s !== 8'd45 || co !== 1'b1) begin errors++; $display("FAIL carry_cin got %0d/%0b exp 45/1", s, co); end
        checks++;
        if (ok !== 1'b1 || lat !== W + 1) begin errors++; $display("FAIL carry_hold got ok=%0b lat=%0d exp 1/%0d", ok, lat, W + 1); end
    endtask

    task automatic test_random();
        logic [W-1:0] s, x, y; logic co, ov, ok, ci, op; int lat;
        logic [W:0] exp;
        for (int i = 0; i < 24; i++) begin
            x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            op = 1'($urandom);
`else
            op = 1'b0;
`endif
            run_op8(x, y, ci, op, s, co, ov, lat, ok);
            exp = model_res(x, y, ci, op);
            checks++;
            if ({co, s} !== exp || lat !== W + 1 || ok !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d x=%0d y=%0d ci=%0b sub=%0b got %0d/%0b lat=%0d exp %0d/%0b lat=%0d",
                         i, x, y, ci, op, s, co, lat, exp[W-1:0], exp[W], W + 1);
            end
`ifdef SERIAL_ADD_SUB_EN
            checks++;
            if (ov !== model_ovf(x, y, ci, op)) begin
                errors++;
                $display("FAIL random_ovf_%0d got %0b exp %0b", i, ov, model_ovf(x, y, ci, op));
            end
`endif
        end
    endtask

    task automatic test_ignore_busy();
        int n;
        @(negedge clk);
        a = 8'd1; b = 8'd1; cin = 1'b0; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            // pulse start with other operands on odd SHIFT cycles
            start = n[0];
            a = 8'd50; b = 8'd60; cin = 1'b1;
            if (done === 1'b1) break;
        end
        checks++;
        if (sum !== 8'd2 || n !== W + 1) begin errors++; $display("FAIL ignore_shift got sum=%0d n=%0d exp 2/%0d", sum, n, W + 1); end
        start = 1'b1;               // start during DONE must be dropped
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore_done_idle got busy=%0b exp 0", busy); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sum !== 8'd2) begin errors++; $display("FAIL ignore_done_noqueue got busy=%0b sum=%0d exp 0/2", busy, sum); end
    endtask

    task automatic test_back_to_back();
        int times[$];
        @(negedge clk);
        a = 8'd1; b = 8'd1; cin = 1'b0; start = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b0;
`endif
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) times.push_back(i);
        end
        start = 1'b0;
        checks++;
        if (times.size() != 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", times.size()); end
        else begin
            checks++;
            if (times[0] != W + 1) begin errors++; $display("FAIL b2b_first got %0d exp %0d", times[0], W + 1); end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (times[k] - times[k-1] != W + 2) begin
                    errors++;
                    $display("FAIL b2b_spacing_%0d got %0d exp %0d", k, times[k] - times[k-1], W + 2);
                end
            end
        end
        checks++;
        if (sum !== 8'd2 || cout !== 1'b0) begin errors++; $display("FAIL b2b_sum got %0d/%0b exp 2/0", sum, cout); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] s; logic co, ov, ok; int lat;
        logic seen;
        @(negedge clk);
        a = 8'd9; b = 8'd9; cin = 1'b1; start = 1'b1;
        @(negedge clk);             // 1st SHIFT cycle
        start = 1'b0;
        repeat (2) @(negedge clk);  // 3rd SHIFT cycle
        @(negedge clk);             // 4th SHIFT cycle
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy, done, cout, sum} !== '0) begin
            errors++;
            $display("FAIL reset_mid got busy=%0b done=%0b cout=%0b sum=%0d exp all 0", busy, done, cout, sum);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL reset_mid_nodone got activity=%0b exp 0", seen); end
        run_op8(8'd7, 8'd8, 1'b0, 1'b0, s, co, ov, lat, ok);
        checks++;
        if (s !== 8'd15 || co !== 1'b0 || lat !== W + 1) begin
            errors++;
            $display("FAIL reset_mid_after got %0d/%0b lat=%0d exp 15/0 lat=%0d", s, co, lat, W + 1);
        end
    endtask

    task automatic test_width1();
        int lat, t;
        for (int v = 7; v >= 0; v--) begin
            @(negedge clk);
            a1 = 1'(v >> 2); b1 = 1'(v >> 1); cin1 = 1'(v); start1 = 1'b1;
            t = (v >> 2 & 1) + (v >> 1 & 1) + (v & 1);
            lat = 0;
            while (lat < 10) begin
                @(negedge clk);
                start1 = 1'b0;
                a1 = ~a1; b1 = ~b1; cin1 = ~cin1;
                lat++;
                if (done1 === 1'b1) break;
            end
            checks++;
            if (lat != 2 || sum1 !== 1'(t % 2) || cout1 !== 1'(t / 2)) begin
                errors++;
                $display("FAIL width1_v%0d got sum=%0b cout=%0b lat=%0d exp %0d/%0d lat=2", v, sum1, cout1, lat, t % 2, t / 2);
            end
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        logic [W-1:0] s; logic co, ov, ok; int lat;
        run_op8(8'd5, 8'd7, 1'b1, 1'b1, s, co, ov, lat, ok);
        checks++;
        if (s !== 8'd254 || co !== 1'b0 || ov !== 1'b0) begin errors++; $display("FAIL sub_5_7 got %0d/%0b/%0b exp 254/0/0", s, co, ov); end
        run_op8(8'd128, 8'd1, 1'b0, 1'b1, s, co, ov, lat, ok);
        checks++;
        if (s !== 8'd127 || co !== 1'b1 || ov !== 1'b1) begin errors++; $display("FAIL sub_128_1 got %0d/%0b/%0b exp 127/1/1", s, co, ov); end
        run_op8(8'd127, 8'd1, 1'b0, 1'b0, s, co, ov, lat, ok);
        checks++;
        if (s !== 8'd128 || co !== 1'b0 || ov !== 1'b1) begin errors++; $display("FAIL add_ovf got %0d/%0b/%0b exp 128/0/1", s, co, ov); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_width1();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
